// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: register-map offsets, duty ceiling and output-mux encoding shared by the PWM bank.
// Offsets are functions of the channel count so every parameterisation shares one map layout.
package pwm_bank_pkg;

  typedef enum logic [1:0] {
    OUT_OFF  = 2'd0,
    OUT_HIGH = 2'd1,
    OUT_PWM  = 2'd2
  } out_sel_e;

  typedef enum int {
    REGION_EN_OUT = 0,
    REGION_EN_PWM = 1,
    REGION_DUTY   = 2
  } region_e;

  // Each enable region is NUM_CH/8 bytes wide, so region n starts at n*NB.
  function automatic int region_base(input int num_ch, input region_e region);
    return int'(region) * (num_ch / 8);
  endfunction

  function automatic int en_out_base(input int num_ch);
    return region_base(num_ch, REGION_EN_OUT);
  endfunction

  function automatic int en_pwm_base(input int num_ch);
    return region_base(num_ch, REGION_EN_PWM);
  endfunction

  function automatic int duty_base(input int num_ch);
    return region_base(num_ch, REGION_DUTY);
  endfunction

  function automatic int duty_max(input int duty_w);
    return (1 << duty_w) - 1;
  endfunction

  function automatic out_sel_e out_select(input logic en_out, input logic en_pwm);
    if (!en_out) return OUT_OFF;
    if (!en_pwm) return OUT_HIGH;
    return OUT_PWM;
  endfunction

  function automatic logic out_mux(input out_sel_e sel, input logic raw);
    case (sel)
      OUT_HIGH: return 1'b1;
      OUT_PWM:  return raw;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pwm_bank_timebase.sv
// pwm_timebase: prescaler, shared period counter and period_start pulse for every channel.
// The wrap strobe is exported only when PWM_SHADOW_EN is defined, for the duty shadow load.
module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int DIV    = 13,
  parameter int DUTY_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [DUTY_W-1:0] cnt_o,
  output logic              period_start_o
`ifdef PWM_SHADOW_EN
  ,
  output logic              wrap_o
`endif
);

  localparam int                PRESC_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [DUTY_W-1:0]  MAX        = DUTY_W'(duty_max(DUTY_W));

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DUTY_W-1:0]  cnt_q, cnt_d;
  logic               periodStart_q, periodStart_d;
  logic               tick;
  logic               wrap;

  // With DIV=1 the prescaler is pinned at 0 and every cycle is a tick.
  assign tick = (presc_q == PRESC_LAST);
  assign wrap = tick && (cnt_q == MAX);

  always_comb begin
    presc_d       = tick ? '0 : presc_q + PRESC_W'(1);
    cnt_d         = tick ? cnt_q + DUTY_W'(1) : cnt_q;
    periodStart_d = wrap;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q       <= '0;
      cnt_q         <= '0;
      periodStart_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      periodStart_q <= periodStart_d;
    end
  end

  assign cnt_o          = cnt_q;
  assign period_start_o = periodStart_q;
`ifdef PWM_SHADOW_EN
  assign wrap_o         = wrap;
`endif

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: NUM_CH-channel PWM generator with byte-wide enable and duty registers.
// Define PWM_SHADOW_EN to double-buffer duty so new values only apply at period boundaries.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DUTY_W = 8,
  parameter int DIV    = 13,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  localparam int                NB          = NUM_CH / 8;
  localparam int                EN_OUT_BASE = en_out_base(NUM_CH);
  localparam int                EN_PWM_BASE = en_pwm_base(NUM_CH);
  localparam int                DUTY_BASE   = duty_base(NUM_CH);
  localparam logic [DUTY_W-1:0] MAX         = DUTY_W'(duty_max(DUTY_W));

  logic [NUM_CH-1:0] enOut_q, enOut_d;
  logic [NUM_CH-1:0] enPwm_q, enPwm_d;
  logic [DUTY_W-1:0] duty_q [NUM_CH];
  logic [DUTY_W-1:0] duty_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [DUTY_W-1:0] cnt;
  int                wrIdx;
  int                rdIdx;
`ifdef PWM_SHADOW_EN
  logic              wrap;
`endif

  assign wrIdx = int'(wr_addr);
  assign rdIdx = int'(rd_addr);

  // Unmapped write addresses fall through every compare and leave the file untouched.
  always_comb begin
    enOut_d = enOut_q;
    enPwm_d = enPwm_q;
    for (int c = 0; c < NUM_CH; c++) duty_d[c] = duty_q[c];
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wrIdx == EN_OUT_BASE + k) enOut_d[8*k +: 8] = wr_data;
        if (wrIdx == EN_PWM_BASE + k) enPwm_d[8*k +: 8] = wr_data;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (wrIdx == DUTY_BASE + c) duty_d[c] = wr_data[DUTY_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enOut_q <= '0;
      enPwm_q <= '0;
      for (int c = 0; c < NUM_CH; c++) duty_q[c] <= '0;
    end else begin
      enOut_q <= enOut_d;
      enPwm_q <= enPwm_d;
      for (int c = 0; c < NUM_CH; c++) duty_q[c] <= duty_d[c];
    end
  end

  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < NB; k++) begin
      if (rdIdx == EN_OUT_BASE + k) rd_data = enOut_q[8*k +: 8];
      if (rdIdx == EN_PWM_BASE + k) rd_data = enPwm_q[8*k +: 8];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (rdIdx == DUTY_BASE + c) rd_data = 8'(duty_q[c]);
    end
  end

  pwm_timebase #(
    .DIV    (DIV),
    .DUTY_W (DUTY_W)
  ) u_timebase (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cnt_o          (cnt),
    .period_start_o (period_start)
`ifdef PWM_SHADOW_EN
    ,
    .wrap_o         (wrap)
`endif
  );

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DUTY_W-1:0] activeDuty;
    logic              raw;
`ifdef PWM_SHADOW_EN
    // Loading from duty_d lets a write landing on the wrap tick join the new period.
    logic [DUTY_W-1:0] shadow_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    shadow_q <= '0;
      else if (wrap) shadow_q <= duty_d[ch];
    end
    assign activeDuty = shadow_q;
`else
    assign activeDuty = duty_q[ch];
`endif
    // Full-scale duty is forced high so 100% really has no low tick per period.
    assign raw       = (activeDuty == MAX) || (cnt < activeDuty);
    assign pwm_d[ch] = out_mux(out_select(enOut_q[ch], enPwm_q[ch]), raw);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= pwm_d;
  end

  assign pwm_out = pwm_q;

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Parametrised multi-channel PWM generator with an internal control register file.
- Replaces the single shared duty-cycle scheme with independent per-channel duty, output-enable and PWM-enable.
- Sits behind the SPI peripheral: the peripheral issues byte writes and reads, and the bank drives the output pins.

Parameters:
- NUM_CH, 16, number of channels; must be a multiple of 8, range 8..64.
- DUTY_W, 8, duty and period-counter width in bits; range 2..8.
- DIV, 13, clock cycles per counter tick; must be at least 1.
- ADDR_W, 7, register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe, one cycle per write.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  8  write data.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  8  combinational read of the register at rd_addr.
- pwm_out  out  NUM_CH  channel outputs, registered.
- period_start  out  1  one-cycle pulse on the first clk of each PWM period.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). All registers, the prescaler and the counter clear to 0. pwm_out=0, period_start=0.
- Register map, with NB = NUM_CH/8:
  - Addresses 0..NB-1: en_out bytes; bit b of byte k is channel 8k+b.
  - Addresses NB..2NB-1: en_pwm bytes, same bit mapping.
  - Addresses 2NB..2NB+NUM_CH-1: duty[ch], held in the low DUTY_W bits.
  - Writes to any other address are ignored.
  - rd_data returns 0 for unmapped addresses and for the unused high bits of duty.
- Writes take effect on the clk edge where wr_en=1. A read of the same address on the next cycle returns the new value.
- Prescaler counts 0..DIV-1. A tick fires when it wraps. With DIV=1, every cycle is a tick.
- Period counter cnt (DUTY_W bits) advances by 1 on each tick and wraps from MAX=2^DUTY_W-1 to 0.
- period_start pulses for one cycle on the tick where cnt goes MAX->0.
- Effective duty d per channel:
  - raw = (cnt < d).
  - Exception: d==MAX gives constant 1 (100%).
  - d==0 gives constant 0.
- pwm_out[ch], registered, one cycle after the inputs change:
  - en_out=0 -> 0.
  - en_out=1, en_pwm=0 -> 1 (static high).
  - en_out=1, en_pwm=1 -> raw.
- A write coinciding with a tick is applied first; the output reflects both on the following cycle.
- Duty writes never disturb cnt or the prescaler.
- Reset asserted mid-period clears everything immediately. After release, counting restarts from cnt=0 with no period_start pulse until the first wrap.

Optional Feature:
- Macro: PWM_SHADOW_EN.
- Defined:
  - Each channel has an active_duty shadow register.
  - Writes land in the programmed register, which is what rd_data returns.
  - All active_duty registers load from the programmed values on the period_start tick, so a period is never glitched.
  - Shadows reset to 0.
  - A write on the wrap tick is captured at that same wrap.
- Undefined: raw compares directly against the programmed duty, and a new duty takes effect the next cycle.

Decomposition:
- Package pwm_bank_pkg holds:
  - Address-offset functions of NUM_CH: EN_OUT_BASE=0, EN_PWM_BASE=NB, DUTY_BASE=2NB.
  - The MAX constant helper.
  - The output-mux encoding.
- One sub-module, pwm_timebase, holds the prescaler, cnt and period_start. It is shared by all channels.
- Channel compare and the output mux are a generate loop in pwm_bank.

Test Plan:
- Reset and static outputs:
  - Reset -> pwm_out=0, rd_data=0 at all mapped addresses.
  - Write en_out[0]=0x01, en_pwm=0 -> pwm_out[0]=1 constantly from the second cycle after the write.
- 50% duty: DIV=13, DUTY_W=8, ch3 duty=0x80 with both enables set -> high for 128 ticks (1664 clk) in each 256-tick period (3328 clk); period_start spacing 3328 clk.
- Duty boundaries: duty=0x00 -> always 0; duty=0xFF -> always 1 across 3 periods; duty=0x01 -> high 13 clk per period.
- Address handling:
  - Write to address 2NB+NUM_CH (unmapped) -> no register changes, readback 0.
  - Write then read en_pwm byte 1 = 0xA5 -> rd_data=0xA5.
- Shadow mode (PWM_SHADOW_EN defined): change duty 0x40->0xC0 mid-period -> current period keeps 64 high ticks, next period has 192; readback is 0xC0 immediately. Undefined -> change visible the next cycle.
- Reset mid-operation: assert rst_n low at cnt=0x77 -> pwm_out=0 within the same cycle. After release, the first period_start arrives 256*DIV clk later.
